// File: rtl/fifo_stream_rdr_pkg.sv
// Shared types and word-layout helpers for the FIFO stream reader.
// Words are {eop, sop, payload}; sop/eop sit just above the payload.
package fifo_stream_rdr_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IN_FRAME = 2'd1,
        DISCARD  = 2'd2
    } rdr_state_e;

    localparam int DWIDTH_DEF = 64;
    localparam int SOP_BIT    = DWIDTH_DEF;
    localparam int EOP_BIT    = DWIDTH_DEF + 1;

    // Width-generic forms of SOP_BIT/EOP_BIT for non-default payload widths.
    function automatic int sop_bit(input int dwidth);
        return dwidth;
    endfunction

    function automatic int eop_bit(input int dwidth);
        return dwidth + 1;
    endfunction

endpackage

// File: rtl/fifo_stream_skid.sv
// fifo_stream_skid: 2-entry output buffer, push visible at head next cycle.
// Caller owns flow control: never push into a full buffer unless popping that cycle.
module fifo_stream_skid #(
    parameter int WIDTH = 66
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic             head_vld_o,
    output logic [WIDTH-1:0] head_dat_o,
    output logic [1:0]       occ_o
);

    logic [WIDTH-1:0] ent0_q, ent0_d;
    logic [WIDTH-1:0] ent1_q, ent1_d;
    logic [1:0]       occ_q, occ_d;

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        case ({push_i, pop_i})
            2'b10: begin
                if (occ_q == 2'd0) ent0_d = push_dat_i;
                else               ent1_d = push_dat_i;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy is unchanged; the new word lands behind whatever remains.
                if (occ_q == 2'd2) begin
                    ent0_d = ent1_q;
                    ent1_d = push_dat_i;
                end else begin
                    ent0_d = push_dat_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign head_vld_o = (occ_q != 2'd0);
    assign head_dat_o = ent0_q;
    assign occ_o      = occ_q;

endmodule

// File: rtl/fifo_stream_rdr.sv
// fifo_stream_rdr: pops a 1-cycle-latency FIFO, enforces sop/eop framing, streams words out (2 cycles fifo_ren->out_valid).
// out_ready low stops reads once 2 words are buffered/in flight; FIFO_STREAM_RDR_STATS_EN adds frame_cnt/err_cnt.
module fifo_stream_rdr
    import fifo_stream_rdr_pkg::*;
#(
    parameter int DWIDTH     = 64,
    parameter int FIFO_WIDTH = DWIDTH + 2
) (
    input  logic                  rclk,
    input  logic                  rrst,
    output logic                  fifo_ren,
    input  logic [FIFO_WIDTH-1:0] fifo_rdata,
    input  logic                  fifo_rempty,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DWIDTH-1:0]     out_data,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic                  err_pulse,
    output logic                  busy
`ifdef FIFO_STREAM_RDR_STATS_EN
    ,
    output logic [31:0]           frame_cnt,
    output logic [15:0]           err_cnt
`endif
);

    localparam int SOP_IDX = sop_bit(DWIDTH);
    localparam int EOP_IDX = eop_bit(DWIDTH);

    rdr_state_e            state_q, state_d;
    logic                  rd_vld_q, rd_vld_d;
    logic                  err_q, err_d;
    logic                  fwd;
    logic                  pop;
    logic                  ren;
    logic                  rd_sop, rd_eop;
    logic [1:0]            occ;
    logic [2:0]            credit;
    logic [FIFO_WIDTH-1:0] head_dat;

    assign rd_sop = fifo_rdata[SOP_IDX];
    assign rd_eop = fifo_rdata[EOP_IDX];

    always_comb begin
        state_d = state_q;
        fwd     = 1'b0;
        err_d   = 1'b0;
        if (rd_vld_q) begin
            case (state_q)
                IDLE: begin
                    if (rd_sop) begin
                        fwd     = 1'b1;
                        state_d = rd_eop ? IDLE : IN_FRAME;
                    end else begin
                        err_d   = 1'b1;
                        state_d = rd_eop ? IDLE : DISCARD;
                    end
                end
                IN_FRAME: begin
                    // A sop here abandons the open frame and starts a new one.
                    fwd     = 1'b1;
                    err_d   = rd_sop;
                    state_d = rd_eop ? IDLE : IN_FRAME;
                end
                DISCARD: begin
                    if (rd_sop) begin
                        fwd     = 1'b1;
                        state_d = rd_eop ? IDLE : IN_FRAME;
                    end else if (rd_eop) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Words leaving this cycle free space now; dropped returns never occupy any.
    assign pop      = out_valid & out_ready;
    assign credit   = {1'b0, occ} - {2'b00, pop} + {2'b00, fwd};
    assign ren      = ~rrst & ~fifo_rempty & (credit < 3'd2);
    assign rd_vld_d = ren;
    assign fifo_ren = ren;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q  <= IDLE;
            rd_vld_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_vld_q <= rd_vld_d;
            err_q    <= err_d;
        end
    end

    fifo_stream_skid #(
        .WIDTH (FIFO_WIDTH)
    ) u_skid (
        .clk_i      (rclk),
        .rst_i      (rrst),
        .push_i     (fwd),
        .push_dat_i (fifo_rdata),
        .pop_i      (pop),
        .head_vld_o (out_valid),
        .head_dat_o (head_dat),
        .occ_o      (occ)
    );

    assign out_data  = head_dat[DWIDTH-1:0];
    assign out_sop   = head_dat[SOP_IDX];
    assign out_eop   = head_dat[EOP_IDX];
    assign err_pulse = err_q;
    assign busy      = (state_q != IDLE) | out_valid;

`ifdef FIFO_STREAM_RDR_STATS_EN
    logic [31:0] frame_cnt_q;
    logic [15:0] err_cnt_q;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            frame_cnt_q <= 32'd0;
            err_cnt_q   <= 16'd0;
        end else begin
            if (fwd & rd_eop)
                frame_cnt_q <= frame_cnt_q + 32'd1;
            if (err_d && (err_cnt_q != 16'hFFFF))
                err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_stream_rdr.sv
// Bench for fifo_stream_rdr: queue-based FIFO model, word-level framing model, scoreboard on every valid cycle.
module tb_fifo_stream_rdr;

    localparam int DW  = 64;
    localparam int FW  = DW + 2;
    localparam int SOP = DW;
    localparam int EOP = DW + 1;

    logic          rclk;
    logic          rrst;
    logic          fifo_ren;
    logic [FW-1:0] fifo_rdata;
    logic          fifo_rempty;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_sop;
    logic          out_eop;
    logic          err_pulse;
    logic          busy;
`ifdef FIFO_STREAM_RDR_STATS_EN
    logic [31:0]   frame_cnt;
    logic [15:0]   err_cnt;
`endif

    fifo_stream_rdr #(
        .DWIDTH     (DW),
        .FIFO_WIDTH (FW)
    ) dut (
        .rclk        (rclk),
        .rrst        (rrst),
        .fifo_ren    (fifo_ren),
        .fifo_rdata  (fifo_rdata),
        .fifo_rempty (fifo_rempty),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .err_pulse   (err_pulse),
        .busy        (busy)
`ifdef FIFO_STREAM_RDR_STATS_EN
        ,
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt)
`endif
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int n_chk = 0;
    int n_err = 0;

    logic [FW-1:0] fq[$];
    logic [FW-1:0] exp_q[$];

    bit m_open, m_junk;
    int exp_err, exp_frames, exp_fwd;
    int err_seen, delivered, pops, vld_cnt, se_beats;
    int cyc, first_ren, first_vld, last_beat;
    bit ren_s, rst_req;
    int rdy_pct, bub_pct;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] rnd_word();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[FW-1:0];
    endfunction

    // Framing model: sop always starts a frame; payload outside a frame is junk.
    task automatic push_word(input bit s, input bit e);
        logic [FW-1:0] w;
        w = rnd_word();
        w[SOP] = s;
        w[EOP] = e;
        fq.push_back(w);
        if (s) begin
            if (m_open) exp_err++;
            exp_q.push_back(w);
            exp_fwd++;
            if (e) exp_frames++;
            m_open = !e;
            m_junk = 1'b0;
        end else if (m_open) begin
            exp_q.push_back(w);
            exp_fwd++;
            if (e) exp_frames++;
            m_open = !e;
        end else begin
            if (!m_junk) exp_err++;
            m_junk = !e;
        end
    endtask

    task automatic clr_all();
        fq.delete();
        exp_q.delete();
        m_open = 0; m_junk = 0;
        exp_err = 0; exp_frames = 0; exp_fwd = 0;
        err_seen = 0; delivered = 0; pops = 0; vld_cnt = 0; se_beats = 0;
        first_ren = -1; first_vld = -1; last_beat = -1;
    endtask

    task automatic monitor();
        logic [FW-1:0] h;
        cyc++;
        ren_s = fifo_ren;
        if (rrst) begin
            chk("ren_in_rst", fifo_ren, 0);
        end else begin
            if (fifo_ren) begin
                chk("ren_when_empty", fifo_rempty, 0);
                pops++;
                if (first_ren < 0) first_ren = cyc;
            end
            if (err_pulse) err_seen++;
            if (out_valid) begin
                vld_cnt++;
                if (first_vld < 0) first_vld = cyc;
                if (exp_q.size() == 0) begin
                    chk("spurious_vld", out_valid, 0);
                end else begin
                    h = exp_q[0];
                    chk("beat_data", out_data, h[DW-1:0]);
                    chk("beat_sop", out_sop, h[SOP]);
                    chk("beat_eop", out_eop, h[EOP]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        delivered++;
                        last_beat = cyc;
                        if (out_sop && out_eop) se_beats++;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge rclk);
        #1;
        if (ren_s && fq.size() > 0) fifo_rdata = fq.pop_front();
        else                        fifo_rdata = rnd_word();
        rrst        = rst_req;
        out_ready   = ($urandom_range(99) < rdy_pct);
        fifo_rempty = (fq.size() == 0) || ($urandom_range(99) < bub_pct);
        @(negedge rclk);
        monitor();
    endtask

    task automatic apply_reset();
        rst_req = 1; bub_pct = 0;
        step();
        clr_all();
        step();
        rst_req = 0;
        step();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        rdy_pct = 100; bub_pct = 0;
        while ((exp_q.size() != 0 || fq.size() != 0) && n < budget) begin
            step();
            n++;
        end
        repeat (4) step();
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ren"}, fifo_ren, 0);
        chk({tag, "_vld"}, out_valid, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_sop"}, out_sop, 0);
        chk({tag, "_eop"}, out_eop, 0);
        chk({tag, "_err"}, err_pulse, 0);
        chk({tag, "_busy"}, busy, 0);
`ifdef FIFO_STREAM_RDR_STATS_EN
        chk({tag, "_fcnt"}, frame_cnt, 0);
        chk({tag, "_ecnt"}, err_cnt, 0);
`endif
    endtask

    task automatic chk_stats(input string tag);
`ifdef FIFO_STREAM_RDR_STATS_EN
        chk({tag, "_fcnt"}, frame_cnt, exp_frames);
        chk({tag, "_ecnt"}, err_cnt, exp_err);
`else
        chk({tag, "_nostats_err"}, err_seen, exp_err);
`endif
    endtask

    initial begin
        int n;
        rrst = 1; out_ready = 0; fifo_rempty = 1; fifo_rdata = '0;
        rst_req = 1; rdy_pct = 0; bub_pct = 0; ren_s = 0; cyc = 0;
        clr_all();

        // Reset: fifo_ren held low even with data available.
        step(); step();
        fq.push_back(rnd_word());
        step();
        fq.delete();
        rst_req = 0;
        step();
        chk_reset_vals("init");

        // 4-word frame, no backpressure: 2-cycle latency, 4 back-to-back beats.
        apply_reset();
        rdy_pct = 100;
        push_word(1, 0); push_word(0, 0); push_word(0, 0); push_word(0, 1);
        n = 0;
        while (delivered < 4 && n < 30) begin step(); n++; end
        chk("lat_beats", delivered, 4);
        chk("lat_first", first_vld - first_ren, 2);
        chk("lat_bubbles", last_beat - first_vld, 3);

        // Mid-frame stall of 10 cycles.
        apply_reset();
        rdy_pct = 100;
        push_word(1, 0);
        for (int i = 0; i < 6; i++) push_word(0, 0);
        push_word(0, 1);
        n = 0;
        while (delivered < 2 && n < 30) begin step(); n++; end
        rdy_pct = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i >= 2) chk("stall_ren", fifo_ren, 0);
        end
        chk("stall_ahead", pops - delivered, 2);
        drain(60);
        chk("stall_total", delivered, 8);

        // Junk outside a frame is dropped with a single error.
        apply_reset();
        rdy_pct = 100;
        push_word(0, 0); push_word(0, 0); push_word(0, 0); push_word(0, 1);
        drain(40);
        chk("junk_vld", vld_cnt, 0);
        chk("junk_err", err_seen, exp_err);
        chk("junk_busy", busy, 0);
        chk_stats("junk");

        // sop inside an open frame.
        apply_reset();
        rdy_pct = 100;
        push_word(1, 0); push_word(0, 0); push_word(1, 0); push_word(0, 0); push_word(0, 1);
        drain(40);
        chk("resop_err", err_seen, exp_err);
        chk("resop_beats", delivered, 5);
        chk_stats("resop");

        // Reset one cycle after a read.
        apply_reset();
        rdy_pct = 100;
        for (int i = 0; i < 6; i++) push_word(i == 0, i == 5);
        n = 0;
        while (!ren_s && n < 20) begin step(); n++; end
        rst_req = 1;
        step();
        clr_all();
        rst_req = 0;
        step();
        chk_reset_vals("midrst");
        push_word(1, 0); push_word(0, 0); push_word(0, 0); push_word(0, 1);
        drain(40);
        chk("midrst_beats", delivered, 4);
        chk("midrst_err", err_seen, 0);

        // Three single-word frames back to back.
        apply_reset();
        rdy_pct = 100;
        push_word(1, 1); push_word(1, 1); push_word(1, 1);
        drain(40);
        chk("single_beats", se_beats, 3);
        chk("single_last", last_beat - first_vld, 2);
        chk_stats("single");

        // Randomized traffic, backpressure and empty bubbles.
        apply_reset();
        rdy_pct = 70; bub_pct = 15;
        for (int i = 0; i < 1500; i++) begin
            if (i % 300 == 0) rdy_pct = $urandom_range(100, 20);
            if ($urandom_range(99) < 60 && fq.size() < 6)
                push_word($urandom_range(99) < 30, $urandom_range(99) < 30);
            step();
        end
        drain(200);
        chk("rnd_fwd", delivered, exp_fwd);
        chk("rnd_err", err_seen, exp_err);
        chk_stats("rnd");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
